// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/response bundle for the iterative shifter.
//   start_i  - request strobe, sampled by the shifter only while busy_o is low
//   src_i    - operand
//   shamt_i  - shift amount, 0..WIDTH-1
//   dir_i    - 0 = right, 1 = left
//   mode_i   - 00 logical, 01 arithmetic, 10 rotate, 11 logical
//   busy_o   - shift in progress
//   done_o   - one-cycle completion pulse
//   result_o - registered result, held until the next completion
// Modports: master drives requests, slave is the shifter.
interface iter_shifter_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
);
    logic               start_i;
    logic [WIDTH-1:0]   src_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               dir_i;
    logic [1:0]         mode_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;

    modport master (
        output start_i, src_i, shamt_i, dir_i, mode_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, src_i, shamt_i, dir_i, mode_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle logical/arithmetic/rotate shifter, up to STEP bits per clock.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - iter_shifter_if slave modport (start/operands in, busy/done/result out)
// A request accepted while idle or in the done cycle is latched in full; later input
// changes have no effect until the operation completes.
module iter_shifter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4,
    parameter int unsigned STEP    = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    iter_shifter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [SHAMT_W-1:0] StepL  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   WidthL = (SHAMT_W + 1)'(WIDTH);
    localparam logic [WIDTH-1:0]   Ones   = '1;

    state_e             r_state, w_state_next;
    logic [WIDTH-1:0]   r_data, w_data_next;
    logic [WIDTH-1:0]   r_result, w_result_next;
    logic [SHAMT_W-1:0] r_rem, w_rem_next;
    logic               r_dir, w_dir_next;
    logic [1:0]         r_mode, w_mode_next;

    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W-1:0] w_rem_left;
    logic [SHAMT_W:0]   w_anti;
    logic [WIDTH-1:0]   w_shifted;

    // Bits moved this cycle: a full step, or whatever is left on the final step.
    assign w_k        = (r_rem < StepL) ? r_rem : StepL;
    assign w_rem_left = r_rem - w_k;
    assign w_anti     = WidthL - {1'b0, w_k};

    always_comb begin
        w_shifted = '0;
        if (r_mode == 2'b10) begin
            w_shifted = r_dir ? ((r_data << w_k) | (r_data >> w_anti))
                              : ((r_data >> w_k) | (r_data << w_anti));
        end else if (r_dir) begin
            w_shifted = r_data << w_k;
        end else if (r_mode == 2'b01) begin
            // MSB is never displaced by a right arithmetic shift, so it is still the src sign.
            w_shifted = (r_data >> w_k) | (r_data[WIDTH-1] ? ~(Ones >> w_k) : '0);
        end else begin
            w_shifted = r_data >> w_k;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_data_next   = r_data;
        w_result_next = r_result;
        w_rem_next    = r_rem;
        w_dir_next    = r_dir;
        w_mode_next   = r_mode;
        case (r_state)
            StShift: begin
                w_data_next = w_shifted;
                w_rem_next  = w_rem_left;
                if (w_rem_left == '0) begin
                    w_result_next = w_shifted;
                    w_state_next  = StDone;
                end
            end
            default: begin
                // Idle and done both accept, giving back-to-back issue from done.
                w_state_next = StIdle;
                if (bus.start_i) begin
                    w_data_next = bus.src_i;
                    w_rem_next  = bus.shamt_i;
                    w_dir_next  = bus.dir_i;
                    w_mode_next = bus.mode_i;
                    if (bus.shamt_i == '0) begin
                        w_result_next = bus.src_i;
                        w_state_next  = StDone;
                    end else begin
                        w_state_next = StShift;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_data   <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_dir    <= 1'b0;
            r_mode   <= 2'b00;
        end else begin
            r_state  <= w_state_next;
            r_data   <= w_data_next;
            r_result <= w_result_next;
            r_rem    <= w_rem_next;
            r_dir    <= w_dir_next;
            r_mode   <= w_mode_next;
        end
    end

    assign bus.busy_o   = (r_state == StShift);
    assign bus.done_o   = (r_state == StDone);
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: self-checking bench for iter_shifter, one instance with STEP=1 and one
// with STEP=4 sharing clock, reset and operand wires; sel picks which one gets start_i.
module tb_iter_shifter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iter_shifter_if #(.WIDTH(16), .SHAMT_W(4)) if1 ();
    iter_shifter_if #(.WIDTH(16), .SHAMT_W(4)) if4 ();

    iter_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(if1.slave)
    );
    iter_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .bus(if4.slave)
    );

    logic        sel;
    logic        start;
    logic [15:0] src;
    logic [3:0]  shamt;
    logic        dir;
    logic [1:0]  mode;

    assign if1.start_i = start & ~sel;
    assign if4.start_i = start & sel;
    assign if1.src_i   = src;
    assign if4.src_i   = src;
    assign if1.shamt_i = shamt;
    assign if4.shamt_i = shamt;
    assign if1.dir_i   = dir;
    assign if4.dir_i   = dir;
    assign if1.mode_i  = mode;
    assign if4.mode_i  = mode;

    logic        busy, done;
    logic [15:0] result;
    assign busy   = sel ? if4.busy_o : if1.busy_o;
    assign done   = sel ? if4.done_o : if1.done_o;
    assign result = sel ? if4.result_o : if1.result_o;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word shifts, independent of the per-cycle stepping.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] sh,
                                          input logic d, input logic [1:0] m);
        logic [31:0] dbl;
        if (m == 2'b10) begin
            dbl = {a, a};
            if (d) begin
                dbl = dbl << sh;
                return dbl[31:16];
            end
            dbl = dbl >> sh;
            return dbl[15:0];
        end
        if (d) return a << sh;
        if (m == 2'b01) return 16'($signed(a) >>> sh);
        return a >> sh;
    endfunction

    function automatic int exp_lat(input logic s, input logic [3:0] sh);
        int step;
        step = s ? 4 : 1;
        return 1 + (int'(sh) + step - 1) / step;
    endfunction

    // Presents a request, waits for the accepting edge, then scrambles the inputs.
    task automatic issue(input logic s, input logic [15:0] a, input logic [3:0] sh,
                         input logic d, input logic [1:0] m);
        @(negedge clk);
        sel = s; src = a; shamt = sh; dir = d; mode = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; src = ~a; shamt = ~sh; dir = ~d; mode = ~m;
    endtask

    // lat counts clock edges from the accepting edge to the one that raised done.
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt,
                             output logic [15:0] res);
        lat = lat0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [3:0]  sh;
        logic        d;
        logic [1:0]  m;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          lat, bc;
        logic [15:0] res;

        tbl[0] = '{1'b0, 16'h8001, 4'd1,  1'b0, 2'b00, 16'h4000, 2};
        tbl[1] = '{1'b0, 16'h8001, 4'd4,  1'b1, 2'b00, 16'h0010, 5};
        tbl[2] = '{1'b1, 16'h8000, 4'd15, 1'b0, 2'b01, 16'hFFFF, 5};
        tbl[3] = '{1'b1, 16'h4000, 4'd15, 1'b0, 2'b01, 16'h0000, 5};
        tbl[4] = '{1'b0, 16'h8001, 4'd1,  1'b1, 2'b10, 16'h0003, 2};
        tbl[5] = '{1'b0, 16'h0001, 4'd4,  1'b0, 2'b10, 16'h1000, 5};
        tbl[6] = '{1'b0, 16'hA5A5, 4'd0,  1'b0, 2'b00, 16'hA5A5, 1};
        tbl[7] = '{1'b0, 16'h00F0, 4'd2,  1'b0, 2'b11, 16'h003C, 3};
        tbl[8] = '{1'b1, 16'hA5A5, 4'd0,  1'b1, 2'b10, 16'hA5A5, 1};
        tbl[9] = '{1'b1, 16'h8001, 4'd5,  1'b1, 2'b10, 16'h0030, 3};

        rst = 1'b1; sel = 1'b0; start = 1'b0; src = '0; shamt = '0; dir = 1'b0; mode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy1", 32'(if1.busy_o), 0);
        check("reset done1", 32'(if1.done_o), 0);
        check("reset result1", 32'(if1.result_o), 0);
        check("reset busy4", 32'(if4.busy_o), 0);
        check("reset result4", 32'(if4.result_o), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].s, tbl[i].a, tbl[i].sh, tbl[i].d, tbl[i].m);
            wait_done(1, lat, bc, res);
            check($sformatf("vec%0d result", i), 32'(res), 32'(tbl[i].exp));
            check($sformatf("vec%0d latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d busy cycles", i), bc, tbl[i].lat - 1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse width", i), 32'(done), 0);
        end

        // Start raised mid-shift must be ignored.
        issue(1'b0, 16'h8001, 4'd4, 1'b1, 2'b00);
        @(posedge clk);
        #1;
        start = 1'b1; src = 16'hFFFF; shamt = 4'd1; dir = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3, lat, bc, res);
        check("ignored start result", 32'(res), 32'h0010);
        check("ignored start latency", lat, 5);
        @(posedge clk);
        #1;
        check("ignored start no 2nd op busy", 32'(busy), 0);
        check("ignored start no 2nd done", 32'(done), 0);

        // Back-to-back issue from the done cycle.
        issue(1'b0, 16'h0001, 4'd4, 1'b0, 2'b10);
        wait_done(1, lat, bc, res);
        check("b2b first result", 32'(res), 32'h1000);
        issue(1'b0, 16'h8001, 4'd1, 1'b1, 2'b10);
        check("b2b no bubble busy", 32'(busy), 1);
        wait_done(1, lat, bc, res);
        check("b2b second result", 32'(res), 32'h0003);
        check("b2b second latency", lat, 2);

        // Asynchronous reset mid-shift.
        issue(1'b0, 16'h8001, 4'd4, 1'b1, 2'b00);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 0);
        check("async rst done", 32'(done), 0);
        check("async rst result", 32'(result), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no done during rst", 32'(done), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 16'h0001, 4'd3, 1'b1, 2'b00);
        wait_done(1, lat, bc, res);
        check("post rst result", 32'(res), 32'h0008);
        check("post rst latency", lat, 4);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic        s, d;
            logic [15:0] a;
            logic [3:0]  sh;
            logic [1:0]  m;
            s  = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            sh = 4'($urandom_range(0, 15));
            d  = 1'($urandom_range(0, 1));
            m  = 2'($urandom_range(0, 3));
            issue(s, a, sh, d, m);
            wait_done(1, lat, bc, res);
            check($sformatf("rand%0d result s=%0d a=%h sh=%0d d=%0d m=%0d", i, s, a, sh, d, m),
                  32'(res), 32'(model(a, sh, d, m)));
            check($sformatf("rand%0d latency", i), lat, exp_lat(s, sh));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle shifter; successor to the single-bit, 16-bit combinational left/right shifter.
- Shifts a WIDTH-bit operand by a run-time amount, STEP bits per clock, under a start/busy/done handshake.
- Supports logical, arithmetic and rotate modes.
- Sits beside the ALU as a shared shift unit; the pipeline stalls on busy_o.

Parameters:
WIDTH, 16, operand/result width in bits (power of two, >=4)
SHAMT_W, 4, shift-amount width; must equal log2(WIDTH)
STEP, 1, maximum bits shifted per cycle (power of two, 1..WIDTH/2)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  request; sampled only when busy_o=0
src_i  input  WIDTH  operand, latched on accepted start
shamt_i  input  SHAMT_W  shift amount 0..WIDTH-1, latched on accepted start
dir_i  input  1  0 = right, 1 = left (same encoding as the existing shifter's leftRight)
mode_i  input  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
busy_o  output  1  high while in SHIFT
done_o  output  1  one-cycle pulse; result_o valid from this cycle
result_o  output  WIDTH  registered result; held until the next completion

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-high (clk_i, rst_i).
- On reset: state=IDLE, busy_o=0, done_o=0, result_o=0, internal data/remaining/ctrl regs=0.
- FSM states: IDLE, SHIFT, DONE.
- Start acceptance:
  - start_i is accepted in IDLE or DONE (busy_o=0).
  - On accept: latch src_i, shamt_i, dir_i, mode_i; remaining=shamt_i.
  - If shamt_i=0: next state DONE and result_o<=src_i.
  - Otherwise: next state SHIFT.
- SHIFT, per cycle:
  - k = min(remaining, STEP); data shifted by k; remaining -= k.
  - When the new remaining=0: result_o<=shifted data and next state DONE.
  - start_i is ignored in SHIFT; latched operands are unaffected.
- DONE:
  - done_o=1 for exactly this cycle.
  - Next state is IDLE, or SHIFT/DONE if start_i is accepted this cycle (back-to-back issue, no bubble).
- Latency (start sampled at edge T):
  - shamt>0: done_o high in cycle T+1+ceil(shamt/STEP).
  - shamt=0: done_o high in cycle T+1.
  - busy_o is high for ceil(shamt/STEP) cycles.
- Shift rules:
  - Logical: zero fill, in either direction.
  - Arithmetic right: fills with the latched src MSB. Arithmetic left behaves as logical left.
  - Rotate: bits shifted out re-enter at the opposite end. mode 11 behaves as logical.
- Width rules: shamt is unsigned. No flags are produced and the shifted-out bits are discarded.
- Boundary conditions:
  - shamt=WIDTH-1 with STEP not dividing it: the last step is partial (k=remaining).
  - Input changes after accept do not affect the result.
- Reset mid-operation: all outputs return to reset values asynchronously. No done_o pulse for the aborted op.

Test Plan:
- WIDTH=16, STEP=1, dir=0, mode=00, src=16'h8001, shamt=1 -> result_o=16'h4000; done_o at T+2; busy_o high 1 cycle.
- dir=1, mode=00, src=16'h8001, shamt=4 -> result_o=16'h0010; busy_o high 4 cycles; done_o at T+5. A second start_i asserted at T+2 is ignored (result unchanged).
- STEP=4, dir=0, mode=01, src=16'h8000, shamt=15 -> result_o=16'hFFFF; busy_o high 4 cycles; done_o at T+5. Same with src=16'h4000 -> 16'h0000.
- Rotate: dir=1, src=16'h8001, shamt=1 -> 16'h0003. dir=0, src=16'h0001, shamt=4 -> 16'h1000. Back-to-back start in the DONE cycle is accepted without an idle cycle.
- shamt=0, src=16'hA5A5 -> result_o=16'hA5A5; done_o at T+1; busy_o never asserted. mode=11 with shamt=2, dir=0, src=16'h00F0 -> 16'h003C.
- Assert rst_i asynchronously mid-SHIFT -> busy_o/done_o/result_o=0 immediately with no done pulse. After release, a new start (src=16'h0001, dir=1, shamt=3) -> 16'h0008.
